// File: rtl/interact_regfile_if.sv
// APF bridge access bus between the bridge master and the core settings register file.
// Ports: addr/wr/wr_data/rd driven by the master; rd_data returned by the slave.
// Strobes are single-cycle and carry no flow control, so the slave must accept every access.
interface interact_regfile_if;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wr_data;
  logic        rd;
  logic [31:0] rd_data;

  modport master (output addr, wr, wr_data, rd, input rd_data);
  modport slave  (input addr, wr, wr_data, rd, output rd_data);
endinterface

// File: rtl/interact_regfile.sv
// Core settings register file on the APF bridge: NUM_REGS strided 32-bit slots, read-only
//   mirror slots, per-slot change strobes and a retriggerable core reset pulse.
// Latency: writes visible on reg_q one cycle after the strobe; read data registered (1 cycle).
// Backpressure: none; every single-cycle bridge strobe is accepted unconditionally.
// Ports: clk_74a/reset (sync, active high), bridge (slave modport), ro_data (RO slot sources),
//   reg_q (slot values), reg_upd (per-slot change pulse), core_reset (active-high request).
module interact_regfile #(
  parameter int                   NUM_REGS    = 16,
  parameter logic [31:0]          BASE_ADDR   = 32'hF100_0000,
  parameter logic [31:0]          ADDR_STRIDE = 32'h4,
  parameter logic [31:0]          RST_ADDR    = 32'hF000_0000,
  parameter logic [NUM_REGS-1:0]  RST_MASK    = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter int                   RST_CYCLES  = 8000
) (
  input  logic                     clk_74a,
  input  logic                     reset,
  interact_regfile_if.slave        bridge,
  input  logic [32*NUM_REGS-1:0]   ro_data,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_upd,
  output logic                     core_reset
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  logic [NUM_REGS-1:0] hit;
  logic                rst_hit;
  logic                trig;
  logic [CW-1:0]       rst_cnt;
  logic [31:0]         rd_mux;

  // Exact-match decode: misaligned or out-of-range addresses hit no slot.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (bridge.addr == (BASE_ADDR + 32'(i) * ADDR_STRIDE));
    end
  end

  assign rst_hit = (bridge.addr == RST_ADDR);

  // Masked slots trigger even when read-only or rewritten with the same value.
  assign trig = bridge.wr && (rst_hit || |(hit & RST_MASK));

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_slot
      if (RO_MASK[g]) begin : g_ro
        assign reg_q[32*g +: 32] = ro_data[32*g +: 32];
        assign reg_upd[g]        = 1'b0;
      end else begin : g_rw
        logic [31:0] val;
        logic        upd;

        always_ff @(posedge clk_74a) begin
          if (reset) begin
            val <= '0;
            upd <= 1'b0;
          end else begin
            upd <= 1'b0;
            if (bridge.wr && hit[g]) begin
              val <= bridge.wr_data;
              upd <= (bridge.wr_data != val);
            end
          end
        end

        assign reg_q[32*g +: 32] = val;
        assign reg_upd[g]        = upd;
      end
    end
  endgenerate

  // Writable slots never look at their ro_data lane; fold it here so it is not left dangling.
  logic unused_ro;
  assign unused_ro = ^ro_data;

  // Reload on every trigger so a retrigger extends the pulse without a gap.
  always_ff @(posedge clk_74a) begin
    if (reset || trig) begin
      rst_cnt <= CW'(RST_CYCLES);
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  assign core_reset = (rst_cnt != '0);

  // reg_q is the pre-write value, so a same-cycle read and write returns the old data.
  always_comb begin
    rd_mux = '0;
    if (rst_hit) begin
      rd_mux = {31'b0, core_reset};
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) begin
        rd_mux = reg_q[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      bridge.rd_data <= '0;
    end else if (bridge.rd) begin
      bridge.rd_data <= rd_mux;
    end
  end

endmodule
